// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: opcodes, functs,
// FSM states, PC source selects and the decoded instruction class.
package multicycle_control_fsm_pkg;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] FN_JR     = 6'h08;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

  typedef enum logic [3:0] {
    CL_ALU_R,
    CL_ALU_I,
    CL_LW,
    CL_SW,
    CL_BRANCH,
    CL_J,
    CL_JR,
    CL_JAL,
    CL_ILLEGAL
  } instr_class_t;

  // R-type functs the datapath implements (shifts, add/sub, logic, set-less-than).
  function automatic logic legal_r_funct(input logic [5:0] funct);
    case (funct)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2A, 6'h2B: legal_r_funct = 1'b1;
      default:      legal_r_funct = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_decode.sv
// Combinational instruction decode: opcode/funct -> instruction class and the
// ALU control fields (ALUOp, ALUSrc, I_format, Sftmd).
module multicycle_control_fsm_decode
  import multicycle_control_fsm_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  output instr_class_t iclass,
  output logic [1:0]   alu_op,
  output logic         alu_src,
  output logic         i_format,
  output logic         sftmd,
  output logic         legal
);

  logic r_format;
  logic branch;

  always_comb begin
    r_format = (op == OP_R_TYPE);
    i_format = (op[5:3] == 3'b001);
    branch   = (op == OP_BEQ) || (op == OP_BNE);
    alu_op   = {r_format | i_format, branch};
    alu_src  = i_format | (op == OP_LW) | (op == OP_SW);
    sftmd    = r_format && (funct[5:3] == 3'b000);

    iclass = CL_ILLEGAL;
    if (r_format) begin
      if (funct == FN_JR)
        iclass = CL_JR;
      else if (legal_r_funct(funct))
        iclass = CL_ALU_R;
    end else if (i_format) begin
      iclass = CL_ALU_I;
    end else begin
      case (op)
        OP_LW:          iclass = CL_LW;
        OP_SW:          iclass = CL_SW;
        OP_BEQ, OP_BNE: iclass = CL_BRANCH;
        OP_J:           iclass = CL_J;
        OP_JAL:         iclass = CL_JAL;
        default:        iclass = CL_ILLEGAL;
      endcase
    end
    legal = (iclass != CL_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a timed
// req/ready memory handshake and per-state datapath enables.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Function_opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUOp,
  output logic       ALUSrc,
  output logic       I_format,
  output logic       Sftmd,
  output logic       RegDST,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Jal,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [2:0] state
);

  state_t           state_q, state_d;
  logic [5:0]       op_q, funct_q;
  logic [CNT_W-1:0] cnt_q;

  logic [5:0]   dec_op, dec_funct;
  instr_class_t iclass;
  logic [1:0]   dec_alu_op;
  logic         dec_alu_src, dec_i_format, dec_sftmd, dec_legal;
  logic         mem_phase, timeout, alu_phase;

  // DECODE judges legality on the live IR; every later state sees only the latched copy.
  assign dec_op    = (state_q == S_DECODE) ? Opcode          : op_q;
  assign dec_funct = (state_q == S_DECODE) ? Function_opcode : funct_q;

  multicycle_control_fsm_decode u_decode (
    .op       (dec_op),
    .funct    (dec_funct),
    .iclass   (iclass),
    .alu_op   (dec_alu_op),
    .alu_src  (dec_alu_src),
    .i_format (dec_i_format),
    .sftmd    (dec_sftmd),
    .legal    (dec_legal)
  );

  // A ready in the expiry cycle still completes the access.
  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout   = mem_phase && !mem_ready && (MEM_TIMEOUT != 0) &&
                     (cnt_q == CNT_W'(MEM_TIMEOUT));
  assign alu_phase = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
  assign state     = reset ? 3'd0 : state_q;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = PCSRC_SEQ;
    RegDST     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    Jal        = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    bus_error  = 1'b0;
    ALUOp      = alu_phase ? dec_alu_op   : 2'b00;
    ALUSrc     = alu_phase && dec_alu_src;
    I_format   = alu_phase && dec_i_format;
    Sftmd      = alu_phase && dec_sftmd;

    case (state_q)
      S_FETCH: begin
        if (timeout) begin
          bus_error = 1'b1;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (iclass)
          CL_BRANCH: begin
            PCWrite    = Zero ^ (op_q == OP_BNE);
            PCSrc      = PCSRC_BRANCH;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          CL_J, CL_JR: begin
            PCWrite    = 1'b1;
            PCSrc      = (iclass == CL_JR) ? PCSRC_REG : PCSRC_JUMP;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          CL_JAL: begin
            PCWrite = 1'b1;
            PCSrc   = PCSRC_JUMP;
            state_d = S_WB;
          end
          CL_LW, CL_SW:       state_d = S_MEM;
          CL_ALU_R, CL_ALU_I: state_d = S_WB;
          default:            state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (timeout) begin
          bus_error = 1'b1;
          state_d   = S_FETCH;
        end else begin
          mem_req  = 1'b1;
          MemWrite = (iclass == CL_SW);
          if (mem_ready) begin
            instr_done = (iclass == CL_SW);
            state_d    = (iclass == CL_SW) ? S_FETCH : S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        RegDST     = (iclass == CL_ALU_R);
        MemtoReg   = (iclass == CL_LW);
        Jal        = (iclass == CL_JAL);
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset silences everything, including the edge that aborts an instruction.
    if (reset) begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = PCSRC_SEQ;
      RegDST     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      Jal        = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      bus_error  = 1'b0;
      ALUOp      = 2'b00;
      ALUSrc     = 1'b0;
      I_format   = 1'b0;
      Sftmd      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q    <= Opcode;
        funct_q <= Function_opcode;
      end
      if (timeout || (state_d != state_q))
        cnt_q <= '0;
      else if (mem_req && !mem_ready)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle input vectors with
// hand-computed control outputs, run with MEM_TIMEOUT=4.
module tb_multicycle_control_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Opcode = '0;
  logic [5:0] Function_opcode = '0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemWrite, IRWrite, PCWrite;
  logic [1:0] PCSrc, ALUOp;
  logic       ALUSrc, I_format, Sftmd, RegDST, MemtoReg, RegWrite, Jal;
  logic       instr_done, illegal_op, bus_error;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  multicycle_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .Opcode          (Opcode),
    .Function_opcode (Function_opcode),
    .Zero            (Zero),
    .mem_ready       (mem_ready),
    .mem_req         (mem_req),
    .MemWrite        (MemWrite),
    .IRWrite         (IRWrite),
    .PCWrite         (PCWrite),
    .PCSrc           (PCSrc),
    .ALUOp           (ALUOp),
    .ALUSrc          (ALUSrc),
    .I_format        (I_format),
    .Sftmd           (Sftmd),
    .RegDST          (RegDST),
    .MemtoReg        (MemtoReg),
    .RegWrite        (RegWrite),
    .Jal             (Jal),
    .instr_done      (instr_done),
    .illegal_op      (illegal_op),
    .bus_error       (bus_error),
    .state           (state)
  );

  // outs = {mem_req, MemWrite, IRWrite, PCWrite, PCSrc, RegDST, MemtoReg,
  //         RegWrite, Jal, instr_done, illegal_op, bus_error, state}
  logic [15:0] outs;
  logic [4:0]  alu;
  assign outs = {mem_req, MemWrite, IRWrite, PCWrite, PCSrc, RegDST, MemtoReg,
                 RegWrite, Jal, instr_done, illegal_op, bus_error, state};
  assign alu  = {ALUOp, ALUSrc, I_format, Sftmd};

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        zero;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] o;
    logic [4:0]  a;
  } vec_t;

  function automatic logic [15:0] ov(input logic req, mw, ir, pcw,
                                     input logic [1:0] pcs,
                                     input logic rdst, m2r, rw, jal, done, ill, berr,
                                     input logic [2:0] st);
    return {req, mw, ir, pcw, pcs, rdst, m2r, rw, jal, done, ill, berr, st};
  endfunction

  function automatic logic [15:0] idle(input logic [2:0] st);
    return ov(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, st);
  endfunction

  function automatic logic [15:0] fetch_hit();
    return ov(1, 0, 1, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 3'd0);
  endfunction

  function automatic logic [15:0] fetch_wait();
    return ov(1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 3'd0);
  endfunction

  function automatic vec_t mk(input logic rst, rdy, zero, input logic [5:0] op, fn,
                              input logic [15:0] o, input logic [4:0] a);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.zero = zero; v.op = op; v.fn = fn; v.o = o; v.a = a;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset           = v.rst;
    mem_ready       = v.rdy;
    Zero            = v.zero;
    Opcode          = v.op;
    Function_opcode = v.fn;
  endtask

  task automatic test_reset();
    vec_t v [3];
    v[0] = mk(1, 1, 0, 6'h00, 6'h20, idle(3'd0), 5'b00000);
    v[1] = mk(1, 1, 0, 6'h00, 6'h20, idle(3'd0), 5'b00000);
    v[2] = mk(0, 0, 0, 6'h00, 6'h00, fetch_wait(), 5'b00000);
    for (int i = 0; i < 3; i++) begin
      drive(v[i]); #1;
      if (outs !== v[i].o) begin bad++; $display("FAIL reset c%0d outs got=%h want=%h", i, outs, v[i].o); end
      if (alu !== v[i].a)  begin bad++; $display("FAIL reset c%0d alu got=%b want=%b", i, alu, v[i].a); end
      total += 2;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_add();
    vec_t v [4];
    v[0] = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    v[1] = mk(0, 1, 0, 6'h00, 6'h20, idle(3'd1), 5'b00000);
    // IR fields now garbage: the latched copy must still drive the ALU controls
    v[2] = mk(0, 1, 0, 6'h3F, 6'h3F, idle(3'd2), 5'b10000);
    v[3] = mk(0, 1, 0, 6'h3F, 6'h3F, ov(0,0,0,0,2'd0,1,0,1,0,1,0,0,3'd4), 5'b10000);
    for (int i = 0; i < 4; i++) begin
      drive(v[i]); #1;
      if (outs !== v[i].o) begin bad++; $display("FAIL add c%0d outs got=%h want=%h", i, outs, v[i].o); end
      if (alu !== v[i].a)  begin bad++; $display("FAIL add c%0d alu got=%b want=%b", i, alu, v[i].a); end
      total += 2;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_lw_wait();
    vec_t v [8];
    v[0] = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    v[1] = mk(0, 0, 0, 6'h23, 6'h00, idle(3'd1), 5'b00000);
    v[2] = mk(0, 0, 0, 6'h23, 6'h00, idle(3'd2), 5'b00100);
    v[3] = mk(0, 0, 0, 6'h23, 6'h00, ov(1,0,0,0,2'd0,0,0,0,0,0,0,0,3'd3), 5'b00100);
    v[4] = mk(0, 0, 0, 6'h23, 6'h00, ov(1,0,0,0,2'd0,0,0,0,0,0,0,0,3'd3), 5'b00100);
    v[5] = mk(0, 0, 0, 6'h23, 6'h00, ov(1,0,0,0,2'd0,0,0,0,0,0,0,0,3'd3), 5'b00100);
    v[6] = mk(0, 1, 0, 6'h23, 6'h00, ov(1,0,0,0,2'd0,0,0,0,0,0,0,0,3'd3), 5'b00100);
    v[7] = mk(0, 0, 0, 6'h23, 6'h00, ov(0,0,0,0,2'd0,0,1,1,0,1,0,0,3'd4), 5'b00100);
    for (int i = 0; i < 8; i++) begin
      drive(v[i]); #1;
      if (outs !== v[i].o) begin bad++; $display("FAIL lw c%0d outs got=%h want=%h", i, outs, v[i].o); end
      if (alu !== v[i].a)  begin bad++; $display("FAIL lw c%0d alu got=%b want=%b", i, alu, v[i].a); end
      total += 2;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_branches();
    vec_t v [9];
    v[0] = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    v[1] = mk(0, 1, 0, 6'h04, 6'h00, idle(3'd1), 5'b00000);
    v[2] = mk(0, 1, 1, 6'h00, 6'h00, ov(0,0,0,1,2'd1,0,0,0,0,1,0,0,3'd2), 5'b01000);
    v[3] = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    v[4] = mk(0, 1, 0, 6'h05, 6'h00, idle(3'd1), 5'b00000);
    v[5] = mk(0, 1, 1, 6'h00, 6'h00, ov(0,0,0,0,2'd1,0,0,0,0,1,0,0,3'd2), 5'b01000);
    v[6] = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    v[7] = mk(0, 1, 0, 6'h05, 6'h00, idle(3'd1), 5'b00000);
    v[8] = mk(0, 1, 0, 6'h00, 6'h00, ov(0,0,0,1,2'd1,0,0,0,0,1,0,0,3'd2), 5'b01000);
    for (int i = 0; i < 9; i++) begin
      drive(v[i]); #1;
      if (outs !== v[i].o) begin bad++; $display("FAIL branch c%0d outs got=%h want=%h", i, outs, v[i].o); end
      if (alu !== v[i].a)  begin bad++; $display("FAIL branch c%0d alu got=%b want=%b", i, alu, v[i].a); end
      total += 2;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_jumps();
    vec_t v [10];
    v[0] = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    v[1] = mk(0, 1, 0, 6'h02, 6'h00, idle(3'd1), 5'b00000);
    v[2] = mk(0, 1, 0, 6'h00, 6'h00, ov(0,0,0,1,2'd2,0,0,0,0,1,0,0,3'd2), 5'b00000);
    v[3] = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    v[4] = mk(0, 1, 0, 6'h00, 6'h08, idle(3'd1), 5'b00000);
    v[5] = mk(0, 1, 0, 6'h00, 6'h00, ov(0,0,0,1,2'd3,0,0,0,0,1,0,0,3'd2), 5'b10000);
    v[6] = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    v[7] = mk(0, 1, 0, 6'h03, 6'h00, idle(3'd1), 5'b00000);
    v[8] = mk(0, 1, 0, 6'h00, 6'h00, ov(0,0,0,1,2'd2,0,0,0,0,0,0,0,3'd2), 5'b00000);
    v[9] = mk(0, 1, 0, 6'h00, 6'h00, ov(0,0,0,0,2'd0,0,0,1,1,1,0,0,3'd4), 5'b00000);
    for (int i = 0; i < 10; i++) begin
      drive(v[i]); #1;
      if (outs !== v[i].o) begin bad++; $display("FAIL jump c%0d outs got=%h want=%h", i, outs, v[i].o); end
      if (alu !== v[i].a)  begin bad++; $display("FAIL jump c%0d alu got=%b want=%b", i, alu, v[i].a); end
      total += 2;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_imm_shift();
    vec_t v [8];
    v[0] = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    v[1] = mk(0, 1, 0, 6'h08, 6'h00, idle(3'd1), 5'b00000);
    v[2] = mk(0, 1, 0, 6'h00, 6'h00, idle(3'd2), 5'b10110);
    v[3] = mk(0, 1, 0, 6'h00, 6'h00, ov(0,0,0,0,2'd0,0,0,1,0,1,0,0,3'd4), 5'b10110);
    v[4] = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    v[5] = mk(0, 1, 0, 6'h00, 6'h00, idle(3'd1), 5'b00000);
    v[6] = mk(0, 1, 0, 6'h08, 6'h20, idle(3'd2), 5'b10001);
    v[7] = mk(0, 1, 0, 6'h08, 6'h20, ov(0,0,0,0,2'd0,1,0,1,0,1,0,0,3'd4), 5'b10001);
    for (int i = 0; i < 8; i++) begin
      drive(v[i]); #1;
      if (outs !== v[i].o) begin bad++; $display("FAIL imm_shift c%0d outs got=%h want=%h", i, outs, v[i].o); end
      if (alu !== v[i].a)  begin bad++; $display("FAIL imm_shift c%0d alu got=%b want=%b", i, alu, v[i].a); end
      total += 2;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_fetch_timeout();
    vec_t v [6];
    for (int i = 0; i < 4; i++)
      v[i] = mk(0, 0, 0, 6'h00, 6'h00, fetch_wait(), 5'b00000);
    v[4] = mk(0, 0, 0, 6'h00, 6'h00, ov(0,0,0,0,2'd0,0,0,0,0,0,0,1,3'd0), 5'b00000);
    v[5] = mk(0, 0, 0, 6'h00, 6'h00, fetch_wait(), 5'b00000);
    for (int i = 0; i < 6; i++) begin
      drive(v[i]); #1;
      if (outs !== v[i].o) begin bad++; $display("FAIL fetch_timeout c%0d outs got=%h want=%h", i, outs, v[i].o); end
      if (alu !== v[i].a)  begin bad++; $display("FAIL fetch_timeout c%0d alu got=%b want=%b", i, alu, v[i].a); end
      total += 2;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_illegal();
    vec_t v [6];
    v[0] = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    v[1] = mk(0, 1, 0, 6'h3F, 6'h00, ov(0,0,0,0,2'd0,0,0,0,0,1,1,0,3'd1), 5'b00000);
    v[2] = mk(0, 0, 0, 6'h00, 6'h00, fetch_wait(), 5'b00000);
    v[3] = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    v[4] = mk(0, 1, 0, 6'h00, 6'h3F, ov(0,0,0,0,2'd0,0,0,0,0,1,1,0,3'd1), 5'b00000);
    v[5] = mk(0, 0, 0, 6'h00, 6'h00, fetch_wait(), 5'b00000);
    for (int i = 0; i < 6; i++) begin
      drive(v[i]); #1;
      if (outs !== v[i].o) begin bad++; $display("FAIL illegal c%0d outs got=%h want=%h", i, outs, v[i].o); end
      if (alu !== v[i].a)  begin bad++; $display("FAIL illegal c%0d alu got=%b want=%b", i, alu, v[i].a); end
      total += 2;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_mem_timeout();
    vec_t v [18];
    v[0] = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    v[1] = mk(0, 0, 0, 6'h23, 6'h00, idle(3'd1), 5'b00000);
    v[2] = mk(0, 0, 0, 6'h00, 6'h00, idle(3'd2), 5'b00100);
    for (int i = 3; i < 7; i++)
      v[i] = mk(0, 0, 0, 6'h00, 6'h00, ov(1,0,0,0,2'd0,0,0,0,0,0,0,0,3'd3), 5'b00100);
    v[7] = mk(0, 0, 0, 6'h00, 6'h00, ov(0,0,0,0,2'd0,0,0,0,0,0,0,1,3'd3), 5'b00100);
    v[8] = mk(0, 0, 0, 6'h00, 6'h00, fetch_wait(), 5'b00000);
    // sw whose ready lands exactly on the expiry cycle: completes, no bus_error
    v[9]  = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    v[10] = mk(0, 0, 0, 6'h2B, 6'h00, idle(3'd1), 5'b00000);
    v[11] = mk(0, 0, 0, 6'h00, 6'h00, idle(3'd2), 5'b00100);
    for (int i = 12; i < 16; i++)
      v[i] = mk(0, 0, 0, 6'h00, 6'h00, ov(1,1,0,0,2'd0,0,0,0,0,0,0,0,3'd3), 5'b00100);
    v[16] = mk(0, 1, 0, 6'h00, 6'h00, ov(1,1,0,0,2'd0,0,0,0,0,1,0,0,3'd3), 5'b00100);
    v[17] = mk(0, 1, 0, 6'h00, 6'h00, fetch_hit(), 5'b00000);
    for (int i = 0; i < 18; i++) begin
      drive(v[i]); #1;
      if (outs !== v[i].o) begin bad++; $display("FAIL mem_timeout c%0d outs got=%h want=%h", i, outs, v[i].o); end
      if (alu !== v[i].a)  begin bad++; $display("FAIL mem_timeout c%0d alu got=%b want=%b", i, alu, v[i].a); end
      total += 2;
      @(posedge clock); #1;
    end
  endtask

  // Entered in DECODE (the last fetch of test_mem_timeout already hit).
  task automatic test_reset_in_mem();
    vec_t v [6];
    v[0] = mk(0, 0, 0, 6'h2B, 6'h00, idle(3'd1), 5'b00000);
    v[1] = mk(0, 0, 0, 6'h00, 6'h00, idle(3'd2), 5'b00100);
    v[2] = mk(0, 0, 0, 6'h00, 6'h00, ov(1,1,0,0,2'd0,0,0,0,0,0,0,0,3'd3), 5'b00100);
    v[3] = mk(1, 1, 0, 6'h00, 6'h00, idle(3'd0), 5'b00000);
    v[4] = mk(1, 1, 0, 6'h00, 6'h00, idle(3'd0), 5'b00000);
    v[5] = mk(0, 0, 0, 6'h00, 6'h00, fetch_wait(), 5'b00000);
    for (int i = 0; i < 6; i++) begin
      drive(v[i]); #1;
      if (outs !== v[i].o) begin bad++; $display("FAIL reset_mem c%0d outs got=%h want=%h", i, outs, v[i].o); end
      if (alu !== v[i].a)  begin bad++; $display("FAIL reset_mem c%0d alu got=%b want=%b", i, alu, v[i].a); end
      total += 2;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clock); #1;
    test_reset();
    test_add();
    test_lw_wait();
    test_branches();
    test_jumps();
    test_imm_shift();
    test_fetch_timeout();
    test_illegal();
    test_mem_timeout();
    test_reset_in_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
